btb_nway: RTL and testbench

BTB_NWAY -- requirements
Module: btb_nway

---
 rtl/btb_pkg.sv | 35 +++
 rtl/btb_nway_if.sv | 36 +++
 rtl/btb_nway_replace.sv | 22 ++
 rtl/btb_nway.sv | 152 +++++++++++++++
 tb/tb_btb_nway.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/btb_pkg.sv
// Shared types and constants for the N-way branch target buffer.
// Counter encodings, allocation/reset constants and the stored entry layout.
package btb_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Widest tag occurs at the minimum of two sets; narrower tags are zero-extended.
    localparam int   MAX_TAGW    = 29;
    localparam logic VALID_RESET = 1'b0;
    localparam ctr_e CTR_ALLOC   = WT;

    typedef struct packed {
        logic                valid;
        logic [MAX_TAGW-1:0] tag;
        logic [31:0]         target;
        ctr_e                state;
    } btb_entry_t;

    function automatic ctr_e ctr_next(input ctr_e s, input logic taken);
        ctr_e n;
        n = s;
        if (taken && (s != ST)) begin
            n = ctr_e'(s + 2'b01);
        end else if (!taken && (s != SNT)) begin
            n = ctr_e'(s - 2'b01);
        end
        return n;
    endfunction

endpackage

// File: rtl/btb_nway_if.sv
// Fetch, update and (optionally) performance signals of the BTB.
// Optional perf counters are present only when BTB_PERF_EN is defined.
interface btb_nway_if;
    logic        flush;
    logic        fetch_valid;
    logic [31:0] pc;
    logic        predict_valid;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        update_en;
    logic [29:0] update_pc;
    logic        actual_taken;
    logic [31:0] update_target;
`ifdef BTB_PERF_EN
    logic [31:0] perf_lookups;
    logic [31:0] perf_hits;

    modport master (
        output flush, fetch_valid, pc, update_en, update_pc, actual_taken, update_target,
        input  predict_valid, predict_taken, predict_target, perf_lookups, perf_hits
    );
    modport slave (
        input  flush, fetch_valid, pc, update_en, update_pc, actual_taken, update_target,
        output predict_valid, predict_taken, predict_target, perf_lookups, perf_hits
    );
`else
    modport master (
        output flush, fetch_valid, pc, update_en, update_pc, actual_taken, update_target,
        input  predict_valid, predict_taken, predict_target
    );
    modport slave (
        input  flush, fetch_valid, pc, update_en, update_pc, actual_taken, update_target,
        output predict_valid, predict_taken, predict_target
    );
`endif
endinterface

// File: rtl/btb_nway_replace.sv
// Victim selection: lowest-index invalid way, otherwise the set's round-robin pointer.
module btb_nway_replace #(
    parameter int WAYS = 4,
    parameter int WAYW = $clog2(WAYS)
) (
    input  logic [WAYS-1:0] valid_i,
    input  logic [WAYW-1:0] ptr_i,
    output logic [WAYW-1:0] victim_o,
    output logic            full_o
);

    always_comb begin
        victim_o = ptr_i;
        full_o   = &valid_i;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_i[w]) begin
                victim_o = WAYW'(w);
            end
        end
    end

endmodule

// File: rtl/btb_nway.sv
// Set-associative BTB with 2-bit direction counters and zero-latency lookup.
// Define BTB_PERF_EN to add saturating lookup/hit counters on the interface.
module btb_nway
    import btb_pkg::*;
#(
    parameter int SETS = 16,
    parameter int WAYS = 4
) (
    input logic       clk,
    input logic       rst,
    btb_nway_if.slave bus
);

    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 30 - IDXW;
    localparam int WAYW = $clog2(WAYS);

    btb_entry_t      entries_q [SETS][WAYS];
    btb_entry_t      entries_d [SETS][WAYS];
    logic [WAYW-1:0] ptr_q [SETS];
    logic [WAYW-1:0] ptr_d [SETS];

    logic [IDXW-1:0] look_idx;
    logic [TAGW-1:0] look_tag;
    logic            look_hit;
    logic [WAYW-1:0] look_way;

    logic [IDXW-1:0] upd_idx;
    logic [TAGW-1:0] upd_tag;
    logic            upd_hit;
    logic [WAYW-1:0] upd_way;
    logic [WAYS-1:0] upd_valid;
    logic [WAYW-1:0] victim;
    logic            set_full;

    assign look_idx = bus.pc[IDXW+1:2];
    assign look_tag = bus.pc[31:IDXW+2];
    assign upd_idx  = bus.update_pc[IDXW-1:0];
    assign upd_tag  = bus.update_pc[29:IDXW];

    // Descending scans so the lowest matching way wins on both ports.
    always_comb begin
        look_hit = 1'b0;
        look_way = '0;
        upd_hit  = 1'b0;
        upd_way  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            upd_valid[w] = entries_q[upd_idx][w].valid;
            if (entries_q[look_idx][w].valid && (entries_q[look_idx][w].tag == MAX_TAGW'(look_tag))) begin
                look_hit = 1'b1;
                look_way = WAYW'(w);
            end
            if (entries_q[upd_idx][w].valid && (entries_q[upd_idx][w].tag == MAX_TAGW'(upd_tag))) begin
                upd_hit = 1'b1;
                upd_way = WAYW'(w);
            end
        end
    end

    assign bus.predict_valid  = look_hit;
    assign bus.predict_taken  = look_hit & entries_q[look_idx][look_way].state[1];
    assign bus.predict_target = look_hit ? entries_q[look_idx][look_way].target : bus.pc + 32'd4;

    btb_nway_replace #(
        .WAYS (WAYS),
        .WAYW (WAYW)
    ) u_replace (
        .valid_i  (upd_valid),
        .ptr_i    (ptr_q[upd_idx]),
        .victim_o (victim),
        .full_o   (set_full)
    );

    // Flush outranks a coincident update; the update is simply dropped.
    always_comb begin
        entries_d = entries_q;
        ptr_d     = ptr_q;
        if (bus.flush) begin
            for (int s = 0; s < SETS; s++) begin
                ptr_d[s] = '0;
                for (int w = 0; w < WAYS; w++) begin
                    entries_d[s][w].valid = VALID_RESET;
                end
            end
        end else if (bus.update_en) begin
            if (upd_hit) begin
                entries_d[upd_idx][upd_way].state = ctr_next(entries_q[upd_idx][upd_way].state, bus.actual_taken);
                if (bus.actual_taken) begin
                    entries_d[upd_idx][upd_way].target = bus.update_target;
                end
            end else if (bus.actual_taken) begin
                entries_d[upd_idx][victim].valid  = 1'b1;
                entries_d[upd_idx][victim].tag    = MAX_TAGW'(upd_tag);
                entries_d[upd_idx][victim].target = bus.update_target;
                entries_d[upd_idx][victim].state  = CTR_ALLOC;
                if (set_full) begin
                    ptr_d[upd_idx] = ptr_q[upd_idx] + WAYW'(1);
                end
            end
        end
    end

    // Reset touches only valid bits and pointers; tags and targets stay as they were.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    entries_q[s][w].valid <= VALID_RESET;
                end
            end
        end else begin
            entries_q <= entries_d;
            ptr_q     <= ptr_d;
        end
    end

`ifdef BTB_PERF_EN
    logic [31:0] perf_lookups_q, perf_lookups_d;
    logic [31:0] perf_hits_q, perf_hits_d;
    logic        unused_pc_bits;

    always_comb begin
        perf_lookups_d = perf_lookups_q;
        perf_hits_d    = perf_hits_q;
        if (bus.fetch_valid && (perf_lookups_q != '1)) begin
            perf_lookups_d = perf_lookups_q + 32'd1;
        end
        if (bus.fetch_valid && look_hit && (perf_hits_q != '1)) begin
            perf_hits_d = perf_hits_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lookups_q <= '0;
            perf_hits_q    <= '0;
        end else begin
            perf_lookups_q <= perf_lookups_d;
            perf_hits_q    <= perf_hits_d;
        end
    end

    assign bus.perf_lookups = perf_lookups_q;
    assign bus.perf_hits    = perf_hits_q;
    assign unused_pc_bits   = ^bus.pc[1:0];
`else
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.pc[1:0], bus.fetch_valid};
`endif

endmodule

// File: tb/tb_btb_nway.sv
// Directed self-checking bench for btb_nway (SETS=16, WAYS=4).
// Perf counter steps are compiled in when BTB_PERF_EN is defined.
module tb_btb_nway;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] p;

    btb_nway_if bus();

    btb_nway #(
        .SETS (16),
        .WAYS (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic fv, input logic [31:0] pcv, input logic ue,
                                 input logic [29:0] upc, input logic at,
                                 input logic [31:0] ut, input logic fl);
        @(negedge clk);
        bus.fetch_valid   = fv;
        bus.pc            = pcv;
        bus.update_en     = ue;
        bus.update_pc     = upc;
        bus.actual_taken  = at;
        bus.update_target = ut;
        bus.flush         = fl;
        #1;
    endtask

    task automatic lookup(input logic [31:0] pcv);
        applyStimulus(1'b0, pcv, 1'b0, 30'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic update(input logic [31:0] bpc, input logic at, input logic [31:0] ut);
        applyStimulus(1'b0, 32'h0, 1'b1, bpc[31:2], at, ut, 1'b0);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 30'h0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 30'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkPredict(input string tag, input logic v, input logic t, input logic [31:0] tgt);
        checkOutput({tag, ".valid"},  {31'h0, bus.predict_valid}, {31'h0, v});
        checkOutput({tag, ".taken"},  {31'h0, bus.predict_taken}, {31'h0, t});
        checkOutput({tag, ".target"}, bus.predict_target, tgt);
    endtask

    initial begin
        $display("[TB] start");
        resetDut();

        lookup(32'h100);
        checkPredict("reset", 1'b0, 1'b0, 32'h104);

        // Same-cycle lookup sees the pre-write contents.
        applyStimulus(1'b0, 32'h100, 1'b1, 30'h40, 1'b1, 32'h2000, 1'b0);
        checkPredict("nobypass", 1'b0, 1'b0, 32'h104);
        lookup(32'h100);
        checkPredict("alloc", 1'b1, 1'b1, 32'h2000);

        update(32'h100, 1'b0, 32'hDEAD0000);
        lookup(32'h100);
        checkPredict("nt1", 1'b1, 1'b0, 32'h2000);
        update(32'h100, 1'b0, 32'hDEAD0000);
        lookup(32'h100);
        checkPredict("nt2", 1'b1, 1'b0, 32'h2000);
        update(32'h100, 1'b0, 32'hDEAD0000);
        update(32'h100, 1'b1, 32'h3000);
        lookup(32'h100);
        checkPredict("sat_low", 1'b1, 1'b0, 32'h3000);
        update(32'h100, 1'b1, 32'h3000);
        lookup(32'h100);
        checkPredict("wt", 1'b1, 1'b1, 32'h3000);
        update(32'h100, 1'b1, 32'h3000);
        update(32'h100, 1'b1, 32'h3000);
        update(32'h100, 1'b0, 32'hBEEF0000);
        lookup(32'h100);
        checkPredict("sat_high", 1'b1, 1'b1, 32'h3000);

        update(32'h500, 1'b0, 32'h4444);
        lookup(32'h500);
        checkPredict("nt_miss", 1'b0, 1'b0, 32'h504);

        applyStimulus(1'b0, 32'h100, 1'b1, 30'h80, 1'b1, 32'h7000, 1'b1);
        lookup(32'h100);
        checkPredict("flush_old", 1'b0, 1'b0, 32'h104);
        lookup(32'h200);
        checkPredict("flush_upd", 1'b0, 1'b0, 32'h204);

        for (int i = 1; i <= 4; i++) begin
            p = i * 32'h1000;
            update(p, 1'b1, 32'hA000 + i * 32'h10);
        end
        for (int i = 1; i <= 4; i++) begin
            p = i * 32'h1000;
            lookup(p);
            checkPredict($sformatf("fill%0d", i), 1'b1, 1'b1, 32'hA000 + i * 32'h10);
        end
        update(32'h5000, 1'b1, 32'hA050);
        lookup(32'h1000);
        checkPredict("evict0", 1'b0, 1'b0, 32'h1004);
        lookup(32'h5000);
        checkPredict("new5", 1'b1, 1'b1, 32'hA050);
        lookup(32'h2000);
        checkPredict("keep2", 1'b1, 1'b1, 32'hA020);
        update(32'h6000, 1'b1, 32'hA060);
        lookup(32'h2000);
        checkPredict("evict1", 1'b0, 1'b0, 32'h2004);
        lookup(32'h3000);
        checkPredict("keep3", 1'b1, 1'b1, 32'hA030);
        lookup(32'h6000);
        checkPredict("new6", 1'b1, 1'b1, 32'hA060);

        update(32'h104, 1'b1, 32'hB000);
        lookup(32'h104);
        checkPredict("set1", 1'b1, 1'b1, 32'hB000);
        lookup(32'h5000);
        checkPredict("set0_keep", 1'b1, 1'b1, 32'hA050);

        resetDut();
        lookup(32'h5000);
        checkPredict("rst_clear", 1'b0, 1'b0, 32'h5004);

`ifdef BTB_PERF_EN
        update(32'h100, 1'b1, 32'h2000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h100, 1'b0, 30'h0, 1'b0, 32'h0, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 32'h900, 1'b0, 30'h0, 1'b0, 32'h0, 1'b0);
        end
        lookup(32'h100);
        checkOutput("perf_lookups", bus.perf_lookups, 32'd10);
        checkOutput("perf_hits", bus.perf_hits, 32'd4);
        resetDut();
        checkOutput("perf_lookups_rst", bus.perf_lookups, 32'd0);
        checkOutput("perf_hits_rst", bus.perf_hits, 32'd0);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
